vend_dispense_ctrl: RTL and testbench

VEND_DISPENSE_CTRL -- requirements
Module: vend_dispense_ctrl

---
 rtl/vend_pkg.sv | 43 ++++
 rtl/vend_coin_select.sv | 38 +++
 rtl/vend_dispense_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : vend_pkg                                                     |
// | Purpose : Shared encodings for the vending dispense controller: FSM    |
// |           states, product codes, coin values, fault codes and prices.  |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MOTOR    = 3'd1,
    ST_PAY_SEL  = 3'd2,
    ST_PAY_WAIT = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  // Product codes
  localparam logic [1:0] PROD_INVALID = 2'd0;
  localparam logic [1:0] PROD_TEA     = 2'd1;
  localparam logic [1:0] PROD_COFFEE  = 2'd2;
  localparam logic [1:0] PROD_CHOC    = 2'd3;

  // Coin denominations in whole zl
  localparam logic [2:0] COIN_NONE = 3'd0;
  localparam logic [2:0] COIN_1    = 3'd1;
  localparam logic [2:0] COIN_2    = 3'd2;
  localparam logic [2:0] COIN_5    = 3'd5;

  // Fault causes
  localparam logic [1:0] FAULT_NONE        = 2'd0;
  localparam logic [1:0] FAULT_MOTOR_TO    = 2'd1;
  localparam logic [1:0] FAULT_CANNOT_PAY  = 2'd2;
  localparam logic [1:0] FAULT_BAD_PRODUCT = 2'd3;

  // Product prices in zl (used by the vending core when computing change)
  localparam logic [7:0] PRICE_TEA    = 8'd2;
  localparam logic [7:0] PRICE_COFFEE = 8'd3;
  localparam logic [7:0] PRICE_CHOC   = 8'd5;

endpackage : vend_pkg
`default_nettype wire

// File: rtl/vend_coin_select.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : vend_coin_select                                             |
// | Purpose : Combinational greedy coin chooser. Picks the largest coin    |
// |           in {5, 2, 1} not exceeding change_owed whose hopper is not   |
// |           empty.                                                       |
// | Ports   : change_owed  in  8  change still to be paid                  |
// |           hopper_empty in  3  bit0 = 1 zl, bit1 = 2 zl, bit2 = 5 zl    |
// |           coin_val     out 3  chosen coin (0 when none qualifies)      |
// |           valid        out 1  a coin qualifies                         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module vend_coin_select
  import vend_pkg::*;
(
  input  logic [7:0] change_owed,
  input  logic [2:0] hopper_empty,
  output logic [2:0] coin_val,
  output logic       valid
);

  always_comb begin
    coin_val = COIN_NONE;
    valid    = 1'b0;
    if ((change_owed >= 8'd5) && !hopper_empty[2]) begin
      coin_val = COIN_5;
      valid    = 1'b1;
    end else if ((change_owed >= 8'd2) && !hopper_empty[1]) begin
      coin_val = COIN_2;
      valid    = 1'b1;
    end else if ((change_owed >= 8'd1) && !hopper_empty[0]) begin
      coin_val = COIN_1;
      valid    = 1'b1;
    end
  end

endmodule : vend_coin_select
`default_nettype wire

// File: rtl/vend_dispense_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : vend_dispense_ctrl                                           |
// | Purpose : Delivers a paid order: drives the product motor handshake,   |
// |           then pays change coin by coin through the hopper handshake.  |
// | Ports   : clk, reset (sync, active-low)                                |
// |           start, product[1:0], change_in[7:0]     order request        |
// |           motor_req, motor_sel[1:0], motor_done   dispense handshake   |
// |           coin_req, coin_val[2:0], coin_ack       hopper handshake     |
// |           hopper_empty[2:0]                       hopper status        |
// |           busy, done, change_owed[7:0]            status               |
// |           fault, fault_code[1:0]                  sticky fault         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int MOTOR_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] product,
  input  logic [7:0] change_in,
  output logic       busy,
  output logic       motor_req,
  output logic [1:0] motor_sel,
  input  logic       motor_done,
  output logic       coin_req,
  output logic [2:0] coin_val,
  input  logic       coin_ack,
  input  logic [2:0] hopper_empty,
  output logic       done,
  output logic [7:0] change_owed,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [15:0] TIMEOUT_CNT = 16'(MOTOR_TIMEOUT);

  state_t      state_q, state_d;
  logic        busy_q, busy_d;
  logic        motor_req_q, motor_req_d;
  logic [1:0]  motor_sel_q, motor_sel_d;
  logic        coin_req_q, coin_req_d;
  logic [2:0]  coin_val_q, coin_val_d;
  logic        done_q, done_d;
  logic [7:0]  change_owed_q, change_owed_d;
  logic        fault_q, fault_d;
  logic [1:0]  fault_code_q, fault_code_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;

  logic [2:0]  sel_coin;
  logic        sel_valid;
  logic [15:0] wait_cnt_inc;
  logic [7:0]  owed_after_coin;

  vend_coin_select u_coin_select (
    .change_owed  (change_owed_q),
    .hopper_empty (hopper_empty),
    .coin_val     (sel_coin),
    .valid        (sel_valid)
  );

  assign wait_cnt_inc    = wait_cnt_q + 16'd1;
  // The chooser never picks a coin larger than change_owed, so this cannot wrap.
  assign owed_after_coin = change_owed_q - {5'd0, coin_val_q};

  always_comb begin
    state_d       = state_q;
    motor_req_d   = motor_req_q;
    motor_sel_d   = motor_sel_q;
    coin_req_d    = coin_req_q;
    coin_val_d    = coin_val_q;
    done_d        = 1'b0;
    change_owed_d = change_owed_q;
    fault_d       = fault_q;
    fault_code_d  = fault_code_q;
    wait_cnt_d    = wait_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          change_owed_d = change_in;
          wait_cnt_d    = 16'd0;
          motor_sel_d   = product;
          if (product == PROD_INVALID) begin
            state_d      = ST_FAULT;
            fault_d      = 1'b1;
            fault_code_d = FAULT_BAD_PRODUCT;
          end else begin
            state_d     = ST_MOTOR;
            motor_req_d = 1'b1;
          end
        end
      end

      ST_MOTOR: begin
        // A completion arriving on the timeout cycle still counts as success.
        if (motor_done) begin
          motor_req_d = 1'b0;
          if (change_owed_q == 8'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_PAY_SEL;
          end
        end else begin
          wait_cnt_d = wait_cnt_inc;
          if (wait_cnt_inc == TIMEOUT_CNT) begin
            state_d      = ST_FAULT;
            motor_req_d  = 1'b0;
            fault_d      = 1'b1;
            fault_code_d = FAULT_MOTOR_TO;
          end
        end
      end

      ST_PAY_SEL: begin
        if (change_owed_q == 8'd0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else if (sel_valid) begin
          state_d    = ST_PAY_WAIT;
          coin_req_d = 1'b1;
          coin_val_d = sel_coin;
        end else begin
          state_d      = ST_FAULT;
          fault_d      = 1'b1;
          fault_code_d = FAULT_CANNOT_PAY;
        end
      end

      ST_PAY_WAIT: begin
        if (coin_ack) begin
          coin_req_d    = 1'b0;
          change_owed_d = owed_after_coin;
          if (owed_after_coin == 8'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_PAY_SEL;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      motor_req_q   <= 1'b0;
      motor_sel_q   <= 2'd0;
      coin_req_q    <= 1'b0;
      coin_val_q    <= 3'd0;
      done_q        <= 1'b0;
      change_owed_q <= 8'd0;
      fault_q       <= 1'b0;
      fault_code_q  <= FAULT_NONE;
      wait_cnt_q    <= 16'd0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      motor_req_q   <= motor_req_d;
      motor_sel_q   <= motor_sel_d;
      coin_req_q    <= coin_req_d;
      coin_val_q    <= coin_val_d;
      done_q        <= done_d;
      change_owed_q <= change_owed_d;
      fault_q       <= fault_d;
      fault_code_q  <= fault_code_d;
      wait_cnt_q    <= wait_cnt_d;
    end
  end

  assign busy        = busy_q;
  assign motor_req   = motor_req_q;
  assign motor_sel   = motor_sel_q;
  assign coin_req    = coin_req_q;
  assign coin_val    = coin_val_q;
  assign done        = done_q;
  assign change_owed = change_owed_q;
  assign fault       = fault_q;
  assign fault_code  = fault_code_q;

endmodule : vend_dispense_ctrl
`default_nettype wire

// File: tb/tb_vend_dispense_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_vend_dispense_ctrl                                        |
// | Purpose : Self-checking bench for vend_dispense_ctrl. Orders are run   |
// |           as transactions; expected coins, change and fault outcomes   |
// |           come from a greedy change-making model of the rules.         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_vend_dispense_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] product;
  logic [7:0] change_in;
  logic       busy;
  logic       motor_req;
  logic [1:0] motor_sel;
  logic       motor_done;
  logic       coin_req;
  logic [2:0] coin_val;
  logic       coin_ack;
  logic [2:0] hopper_empty;
  logic       done;
  logic [7:0] change_owed;
  logic       fault;
  logic [1:0] fault_code;

  int n_cmp = 0;
  int n_err = 0;

  vend_dispense_ctrl #(.MOTOR_TIMEOUT(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .product      (product),
    .change_in    (change_in),
    .busy         (busy),
    .motor_req    (motor_req),
    .motor_sel    (motor_sel),
    .motor_done   (motor_done),
    .coin_req     (coin_req),
    .coin_val     (coin_val),
    .coin_ack     (coin_ack),
    .hopper_empty (hopper_empty),
    .done         (done),
    .change_owed  (change_owed),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Greedy change-making: largest available coin not exceeding what is owed.
  function automatic int pick_coin(input int owed, input logic [2:0] he);
    if (owed >= 5 && !he[2]) return 5;
    if (owed >= 2 && !he[1]) return 2;
    if (owed >= 1 && !he[0]) return 1;
    return 0;
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".busy"},        busy,        0);
    check_eq({tag, ".motor_req"},   motor_req,   0);
    check_eq({tag, ".coin_req"},    coin_req,    0);
    check_eq({tag, ".done"},        done,        0);
    check_eq({tag, ".fault"},       fault,       0);
    check_eq({tag, ".motor_sel"},   motor_sel,   0);
    check_eq({tag, ".coin_val"},    coin_val,    0);
    check_eq({tag, ".fault_code"},  fault_code,  0);
    check_eq({tag, ".change_owed"}, change_owed, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_reset_vals("rst");
    reset = 1'b1;
  endtask

  // Fault must hold, ignoring fresh start requests, until reset.
  task automatic fault_hold(input int exp_owed, input int exp_code);
    repeat (3) begin
      start     = 1'b1;
      product   = 2'($urandom_range(1, 3));
      change_in = 8'($urandom);
      @(negedge clk);
      check_eq("hold.fault",       fault,       1);
      check_eq("hold.code",        fault_code,  exp_code);
      check_eq("hold.owed",        change_owed, exp_owed);
      check_eq("hold.motor_req",   motor_req,   0);
      check_eq("hold.coin_req",    coin_req,    0);
      check_eq("hold.busy",        busy,        1);
    end
    start = 1'b0;
  endtask

  task automatic run_order(input logic [1:0] prod, input logic [7:0] chg,
                           input logic [2:0] he, input bit no_motor,
                           input bit reset_mid_pay);
    int owed;
    int coin;
    int lat;
    int dly;
    hopper_empty = he;
    product      = prod;
    change_in    = chg;
    motor_done   = 1'b0;
    coin_ack     = 1'b0;
    start        = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    product   = 2'($urandom);
    change_in = 8'($urandom);
    check_eq("accept.busy", busy,        1);
    check_eq("accept.owed", change_owed, chg);
    check_eq("accept.done", done,        0);

    if (prod == 2'd0) begin
      check_eq("bad.fault",     fault,      1);
      check_eq("bad.code",      fault_code, 3);
      check_eq("bad.motor_req", motor_req,  0);
      fault_hold(chg, 3);
      do_reset();
      return;
    end

    check_eq("motor.req", motor_req, 1);
    check_eq("motor.sel", motor_sel, prod);
    check_eq("motor.coin_req", coin_req, 0);

    if (no_motor) begin
      for (int i = 1; i <= 10; i++) begin
        coin_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (i == 9) begin
          check_eq("to.early_fault", fault,     0);
          check_eq("to.early_req",   motor_req, 1);
        end
      end
      coin_ack = 1'b0;
      check_eq("to.fault",     fault,       1);
      check_eq("to.code",      fault_code,  1);
      check_eq("to.motor_req", motor_req,   0);
      check_eq("to.owed",      change_owed, chg);
      fault_hold(chg, 1);
      do_reset();
      return;
    end

    lat = $urandom_range(0, 6);
    repeat (lat) begin
      coin_ack = 1'($urandom_range(0, 1));
      start    = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("motor.req_hold", motor_req, 1);
      check_eq("motor.sel_hold", motor_sel, prod);
      check_eq("motor.owed",     change_owed, chg);
    end
    coin_ack   = 1'b0;
    start      = 1'b0;
    motor_done = 1'b1;
    @(negedge clk);
    motor_done = 1'b0;
    check_eq("motor.req_drop", motor_req, 0);

    owed = chg;
    if (owed == 0) begin
      check_eq("nochg.done",     done,     1);
      check_eq("nochg.coin_req", coin_req, 0);
      @(negedge clk);
      check_eq("nochg.done_end", done, 0);
      check_eq("nochg.busy_end", busy, 0);
      return;
    end
    check_eq("motor.done_low", done, 0);

    while (owed > 0) begin
      coin = pick_coin(owed, he);
      @(negedge clk);
      if (coin == 0) begin
        check_eq("pay.fault",    fault,       1);
        check_eq("pay.code",     fault_code,  2);
        check_eq("pay.owed",     change_owed, owed);
        check_eq("pay.coin_req", coin_req,    0);
        fault_hold(owed, 2);
        do_reset();
        return;
      end
      check_eq("pay.coin_req", coin_req, 1);
      check_eq("pay.coin_val", coin_val, coin);
      check_eq("pay.done_low", done,     0);

      if (reset_mid_pay) begin
        reset     = 1'b0;
        start     = 1'b1;
        product   = 2'd2;
        change_in = 8'd9;
        @(negedge clk);
        check_reset_vals("midrst");
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_eq("midrst.busy_after", busy,      0);
        check_eq("midrst.motor_req",  motor_req, 0);
        return;
      end

      dly = $urandom_range(0, 3);
      repeat (dly) begin
        motor_done = 1'($urandom_range(0, 1));
        start      = 1'($urandom_range(0, 1));
        @(negedge clk);
        check_eq("pay.req_hold", coin_req, 1);
        check_eq("pay.val_hold", coin_val, coin);
        check_eq("pay.motor_req", motor_req, 0);
      end
      motor_done = 1'b0;
      start      = 1'b0;
      coin_ack   = 1'b1;
      @(negedge clk);
      coin_ack = 1'b0;
      owed     = owed - coin;
      check_eq("ack.coin_req", coin_req,    0);
      check_eq("ack.owed",     change_owed, owed);
      if (owed == 0) begin
        check_eq("end.done",     done, 1);
        @(negedge clk);
        check_eq("end.done_end", done, 0);
        check_eq("end.busy_end", busy, 0);
      end else begin
        check_eq("ack.done_low", done, 0);
      end
    end
  endtask

  initial begin
    reset        = 1'b0;
    start        = 1'b0;
    product      = 2'd0;
    change_in    = 8'd0;
    motor_done   = 1'b0;
    coin_ack     = 1'b0;
    hopper_empty = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("init");
    reset = 1'b1;
    @(negedge clk);
    check_eq("idle.busy", busy, 0);

    // Directed scenarios
    run_order(2'd2, 8'd8, 3'b000, 1'b0, 1'b0);   // coins 5, 2, 1
    run_order(2'd1, 8'd0, 3'b000, 1'b0, 1'b0);   // motor only
    run_order(2'd3, 8'd6, 3'b100, 1'b0, 1'b0);   // coins 2, 2, 2
    run_order(2'd2, 8'd3, 3'b001, 1'b0, 1'b0);   // 2 paid, then cannot pay
    run_order(2'd1, 8'd4, 3'b000, 1'b1, 1'b0);   // motor timeout
    run_order(2'd0, 8'd7, 3'b000, 1'b0, 1'b0);   // invalid product
    run_order(2'd2, 8'd8, 3'b000, 1'b0, 1'b1);   // reset mid-handshake
    run_order(2'd3, 8'd255, 3'b000, 1'b0, 1'b0); // largest change value

    // Randomized orders
    for (int n = 0; n < 40; n++) begin
      logic [1:0] p;
      logic [2:0] h;
      p = ($urandom_range(0, 9) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      h = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom);
      run_order(p, 8'($urandom_range(0, 20)), h,
                1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_vend_dispense_ctrl
`default_nettype wire
